// File: rtl/wb_initiator_pkg.sv
// Shared types and default sizes for the Wishbone single-transfer initiator.
package wb_initiator_pkg;

  localparam int DEF_ADR_W          = 32;
  localparam int DEF_DAT_W          = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int WAIT_CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                   we;
    logic [DEF_ADR_W-1:0]   adr;
    logic [DEF_DAT_W-1:0]   dat;
    logic [DEF_DAT_W/8-1:0] sel;
  } wb_cmd_t;

endpackage

// File: rtl/wb_initiator_seq_if.sv
// Command, response and Wishbone master signals of the initiator in one bundle.
interface wb_initiator_seq_if
  import wb_initiator_pkg::*;
#(
  parameter int ADR_W = DEF_ADR_W,
  parameter int DAT_W = DEF_DAT_W
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_we;
  logic [ADR_W-1:0]   cmd_adr;
  logic [DAT_W-1:0]   cmd_dat;
  logic [DAT_W/8-1:0] cmd_sel;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DAT_W-1:0]   rsp_dat;
  logic               rsp_err;
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic               wbm_we_o;
  logic [DAT_W/8-1:0] wbm_sel_o;
  logic [ADR_W-1:0]   wbm_adr_o;
  logic [DAT_W-1:0]   wbm_dat_o;
  logic [DAT_W-1:0]   wbm_dat_i;
  logic               wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

endinterface

// File: rtl/wb_wait_timer.sv
// Counts STB cycles without ACK; o_expired flags the TIMEOUT_CYCLES-th such cycle.
module wb_wait_timer
  import wb_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [WAIT_CNT_W-1:0] r_count;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of completed wait cycles, so the current cycle is r_count+1.
  assign o_expired = (r_count == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_initiator_seq.sv
// Wishbone classic single-transfer initiator: one command -> one CYC/STB cycle -> one response.
// Define WB_INITIATOR_TIMEOUT_EN to abort transfers whose slave never ACKs.
module wb_initiator_seq
  import wb_initiator_pkg::*;
#(
  parameter int ADR_W          = DEF_ADR_W,
  parameter int DAT_W          = DEF_DAT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_initiator_seq_if.master bus
);

  typedef struct packed {
    logic               we;
    logic [ADR_W-1:0]   adr;
    logic [DAT_W-1:0]   dat;
    logic [DAT_W/8-1:0] sel;
  } cmd_t;

  wb_state_e          r_state, w_next;
  cmd_t               r_cmd;
  logic               r_cyc;
  logic [DAT_W-1:0]   r_rsp_dat;
  logic               r_rsp_err;
  logic               w_accept;
  logic               w_in_bus;
  logic               w_expired;

  assign w_accept = (r_state == IDLE) && bus.cmd_valid;
  assign w_in_bus = (r_state == BUS);

`ifdef WB_INITIATOR_TIMEOUT_EN
  wb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .i_clear   (w_accept),
    .i_enable  (w_in_bus && !bus.wbm_ack_i),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so no branch leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.cmd_valid)                w_next = BUS;
      BUS:     if (bus.wbm_ack_i || w_expired)   w_next = RESP;
      RESP:    if (bus.rsp_ready)                w_next = IDLE;
      default:                                   w_next = IDLE;
    endcase
  end

  // ACK is tested before expiry so a same-edge ACK completes normally.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      // NOTE: non-blocking everywhere so every register sees pre-edge values.
      r_cyc     <= 1'b0;
      r_cmd     <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_cyc     <= 1'b1;
      r_cmd.we  <= bus.cmd_we;
      r_cmd.adr <= bus.cmd_adr;
      r_cmd.sel <= bus.cmd_sel;
      r_cmd.dat <= bus.cmd_we ? bus.cmd_dat : '0;
    end else if (w_in_bus && bus.wbm_ack_i) begin
      r_cyc     <= 1'b0;
      r_rsp_dat <= r_cmd.we ? '0 : bus.wbm_dat_i;
      r_rsp_err <= 1'b0;
    end else if (w_in_bus && w_expired) begin
      r_cyc     <= 1'b0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b1;
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_dat   = r_rsp_dat;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.wbm_cyc_o = r_cyc;
  assign bus.wbm_stb_o = r_cyc;
  assign bus.wbm_we_o  = r_cmd.we;
  assign bus.wbm_sel_o = r_cmd.sel;
  assign bus.wbm_adr_o = r_cmd.adr;
  assign bus.wbm_dat_o = r_cmd.dat;

endmodule

// File: tb/tb_wb_initiator_seq.sv
// Self-checking bench for wb_initiator_seq; expected responses queued at issue, compared at handshake.
module tb_wb_initiator_seq;
  import wb_initiator_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_initiator_seq_if #(.ADR_W(DEF_ADR_W), .DAT_W(DEF_DAT_W)) bus ();

  wb_initiator_seq #(
    .ADR_W(DEF_ADR_W), .DAT_W(DEF_DAT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.master)
  );

  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_cmd(input wb_cmd_t c);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = c.we;
    bus.cmd_adr   = c.adr;
    bus.cmd_dat   = c.dat;
    bus.cmd_sel   = c.sel;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_bus(input wb_cmd_t c, input int wait_cycles, input logic [31:0] rdata);
    int stb_cnt = 0;
    for (int k = 0; k <= wait_cycles; k++) begin
      if (bus.wbm_cyc_o && bus.wbm_stb_o) stb_cnt++;
      check("bus_adr", bus.wbm_adr_o, c.adr);
      check("bus_sel", bus.wbm_sel_o, c.sel);
      check("bus_we", bus.wbm_we_o, c.we);
      check("bus_dat_o", bus.wbm_dat_o, c.we ? c.dat : 32'h0);
      check("bus_cmd_ready", bus.cmd_ready, 0);
      check("bus_rsp_valid", bus.rsp_valid, 0);
      bus.wbm_ack_i = (k == wait_cycles);
      bus.wbm_dat_i = (k == wait_cycles) ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
    end
    bus.wbm_ack_i = 1'b0;
    check("stb_cycles", stb_cnt, wait_cycles + 1);
    check("stb_drop", bus.wbm_stb_o, 0);
    check("cyc_drop", bus.wbm_cyc_o, 0);
    check("rsp_valid_rise", bus.rsp_valid, 1);
  endtask

  task automatic take_rsp(input int delay);
    rsp_t exp_r;
    exp_r = (sb_q.size() != 0) ? sb_q[0] : '0;
    for (int d = 0; d < delay; d++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_dat", bus.rsp_dat, exp_r.dat);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_adr   = 32'h4000_0000 + d;
      bus.wbm_ack_i = (d == 0);
      bus.wbm_dat_i = 32'h1111_1111;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.wbm_ack_i = 1'b0;
    check("rsp_valid", bus.rsp_valid, 1);
    check("sb_nonempty", sb_q.size() != 0, 1);
    if (sb_q.size() != 0) begin
      exp_r = sb_q.pop_front();
      check("rsp_dat", bus.rsp_dat, exp_r.dat);
      check("rsp_err", bus.rsp_err, exp_r.err);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("idle_after_rsp", bus.cmd_ready, 1);
    check("rsp_valid_drop", bus.rsp_valid, 0);
    check("no_accept_cyc", bus.wbm_cyc_o, 0);
  endtask

  task automatic xfer(input wb_cmd_t c, input int wait_cycles, input logic [31:0] rdata,
                      input int delay);
    sb_q.push_back('{dat: (c.we ? 32'h0 : rdata), err: 1'b0});
    send_cmd(c);
    run_bus(c, wait_cycles, rdata);
    take_rsp(delay);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_cmd_t c;
    int      stb_cnt;
    logic    seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;
    bus.wbm_dat_i = '0;
    bus.wbm_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_cyc", bus.wbm_cyc_o, 0);
    check("rst_stb", bus.wbm_stb_o, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_dat", bus.rsp_dat, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_adr", bus.wbm_adr_o, 0);

    // Write, zero-wait slave.
    c = '{we: 1'b1, adr: 32'h3000_0004, dat: 32'hA5A5_1234, sel: 4'hF};
    xfer(c, 0, 32'hFFFF_0000, 0);

    // Read, three wait states.
    c = '{we: 1'b0, adr: 32'h3000_0010, dat: 32'h5555_AAAA, sel: 4'hF};
    xfer(c, 3, 32'hDEAD_BEEF, 0);

    // Read with 5 cycles of response backpressure and a spurious ACK in RESP.
    c = '{we: 1'b0, adr: 32'h3000_0020, dat: 32'h0, sel: 4'h3};
    xfer(c, 1, 32'hCAFE_F00D, 5);

    // Spurious ACK in IDLE.
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h2222_2222;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    check("spur_idle_cyc", bus.wbm_cyc_o, 0);
    check("spur_idle_rsp", bus.rsp_valid, 0);
    check("spur_idle_ready", bus.cmd_ready, 1);

    // Reset in the second BUS cycle.
    c = '{we: 1'b0, adr: 32'h3000_0030, dat: 32'h0, sel: 4'hF};
    send_cmd(c);
    check("pre_rst_stb", bus.wbm_stb_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cyc", bus.wbm_cyc_o, 0);
    check("mid_rst_stb", bus.wbm_stb_o, 0);
    check("mid_rst_rsp", bus.rsp_valid, 0);
    check("mid_rst_ready", bus.cmd_ready, 1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("mid_rst_no_rsp", seen, 0);

    // Partial-byte write after reset.
    c = '{we: 1'b1, adr: 32'h3000_0044, dat: 32'h1357_9BDF, sel: 4'h6};
    xfer(c, 2, 32'h7777_7777, 2);

`ifdef WB_INITIATOR_TIMEOUT_EN
    // Slave never ACKs: abort after TO strobe cycles.
    c = '{we: 1'b0, adr: 32'h3000_0050, dat: 32'h0, sel: 4'hF};
    sb_q.push_back('{dat: 32'h0, err: 1'b1});
    send_cmd(c);
    stb_cnt = 0;
    for (int k = 0; k < 20 && !bus.rsp_valid; k++) begin
      if (bus.wbm_stb_o) stb_cnt++;
      @(negedge clk);
    end
    check("to_stb_cycles", stb_cnt, TO);
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_stb_drop", bus.wbm_stb_o, 0);
    take_rsp(0);

    // ACK on the expiry edge wins.
    c = '{we: 1'b0, adr: 32'h3000_0054, dat: 32'h0, sel: 4'hF};
    xfer(c, TO - 1, 32'h1234_5678, 0);
`else
    // No timeout: a silent slave stalls the bus indefinitely.
    c = '{we: 1'b0, adr: 32'h3000_0060, dat: 32'h0, sel: 4'hF};
    send_cmd(c);
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      seen |= bus.rsp_valid;
      @(negedge clk);
    end
    check("hang_stb", bus.wbm_stb_o, 1);
    check("hang_cyc", bus.wbm_cyc_o, 1);
    check("hang_no_rsp", seen, 0);
    check("hang_err", bus.rsp_err, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("hang_recover_ready", bus.cmd_ready, 1);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
